rr_arb_2x1_reg: RTL

//  Registered two-source round-robin arbiter, built around the 2:1 n-bit mux.
//  Two valid/ready producers each present an n-bit word. The block grants one

---
 rtl/rr_arb_2x1_reg_pkg.sv | 17 +
 rtl/rr_arb_2x1_reg_if.sv | 29 ++
 rtl/rr_arb_2x1_reg_mux.sv | 14 +
 rtl/rr_arb_2x1_reg.sv | 95 +++++++++
 4 files changed

// File: rtl/rr_arb_2x1_reg_pkg.sv
// Shared definitions for the registered two-source round-robin arbiter.
// Holds the output-register state encoding and the source index constants.
package rr_arb_2x1_reg_pkg;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  // The state encoding equals out_valid, so the output flag is just the state bit.
  typedef enum logic {
    EMPTY = ST_EMPTY,
    FULL  = ST_FULL
  } arb_state_t;

endpackage

// File: rtl/rr_arb_2x1_reg_if.sv
// Handshake bundle for rr_arb_2x1_reg.
// Two valid/ready producer channels (in0_*, in1_*) and one valid/ready
// consumer channel (out_*), which also carries the source index of the word.
//   slave  : arbiter side (takes producer words, drives the consumer)
//   master : environment side (drives producers, acts as the consumer)
interface rr_arb_2x1_reg_if #(
  parameter int n = 3
);
  logic         in0_valid;
  logic [n-1:0] in0_data;
  logic         in0_ready;
  logic         in1_valid;
  logic [n-1:0] in1_data;
  logic         in1_ready;
  logic         out_valid;
  logic [n-1:0] out_data;
  logic         out_src;
  logic         out_ready;

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_src
  );

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_arb_2x1_reg_mux.sv
// 2:1 n-bit word multiplexer.
// Ports: w0, w1 - input words; s - select (0 -> w0, 1 -> w1); f - selected word.
module mux_2x1_nbit #(
  parameter int n = 3
) (
  input  logic [n-1:0] w0,
  input  logic [n-1:0] w1,
  input  logic         s,
  output logic [n-1:0] f
);

  assign f = s ? w1 : w0;

endmodule

// File: rtl/rr_arb_2x1_reg.sv
// Registered two-source round-robin arbiter.
// Grants one of two valid/ready producers per cycle and captures the chosen
// word in a one-deep output register toward a single valid/ready consumer.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - rr_arb_2x1_reg_if.slave (producer and consumer handshakes)
//
// state | meaning
// EMPTY | output register holds no word, any valid source may load
// FULL  | output register holds a word (out_valid=1)
module rr_arb_2x1_reg
  import rr_arb_2x1_reg_pkg::*;
#(
  parameter int n = 3
) (
  input  logic             clk,
  input  logic             reset,
  rr_arb_2x1_reg_if.slave  bus
);

  arb_state_t   state_q;
  logic         last_q;
  logic [n-1:0] data_q;
  logic         src_q;

  logic         load;
  logic         grant;
  logic         rdy0;
  logic         rdy1;
  logic         accept;
  logic [n-1:0] mux_f;

  // A new word may enter when the register is empty or is being drained now.
  assign load = (state_q == EMPTY) | bus.out_ready;

  // Under contention the source that did not win last time gets the grant.
  always_comb begin
    grant = SRC0;
    if (bus.in0_valid & bus.in1_valid) begin
      grant = ~last_q;
    end else if (bus.in1_valid) begin
      grant = SRC1;
    end
  end

  assign rdy0   = load & bus.in0_valid & (grant == SRC0);
  assign rdy1   = load & bus.in1_valid & (grant == SRC1);
  assign accept = rdy0 | rdy1;

  mux_2x1_nbit #(.n(n)) u_mux (
    .w0 (bus.in0_data),
    .w1 (bus.in1_data),
    .s  (grant),
    .f  (mux_f)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      last_q  <= SRC1;
      data_q  <= '0;
      src_q   <= SRC0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= FULL;
            data_q  <= mux_f;
            src_q   <= grant;
            last_q  <= grant;
          end
        end
        FULL: begin
          // Drain and accept in the same cycle replaces the word with no bubble.
          if (accept) begin
            data_q <= mux_f;
            src_q  <= grant;
            last_q <= grant;
          end else if (bus.out_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign bus.in0_ready = rdy0;
  assign bus.in1_ready = rdy1;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

endmodule
